// File: rtl/simple_spi.sv
// Mode-0 SPI master (CPOL=0, CPHA=0, MSB first) with a programmable transfer
// length of 1..reg_width bits; each serial bit spans two sys_clk cycles.
module simple_spi #(
  parameter int reg_width = 16
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 t_begin,
  input  logic [reg_width-1:0] data_in,
  input  logic [reg_width:0]   t_size,
  output logic [reg_width-1:0] data_out,
  output logic                 cs,
  output logic                 spi_clk,
  output logic                 mosi,
  input  logic                 miso
);

  localparam int CW = $clog2(reg_width + 1);

  typedef enum logic [1:0] {
    IDLE,
    TRANSFER,
    FINISH
  } state_t;

  state_t               state_q, state_d;
  logic [reg_width-1:0] tx_q, tx_d;
  logic [reg_width-1:0] rx_q, rx_d;
  logic [reg_width-1:0] dout_q, dout_d;
  logic [CW-1:0]        bits_q, bits_d;
  logic [CW-1:0]        len_q, len_d;
  logic                 cs_q, cs_d;
  logic                 sclk_q, sclk_d;
  logic                 mosi_q, mosi_d;

  logic [CW-1:0]        eff_len;
  logic [CW-1:0]        shamt;
  logic [reg_width-1:0] tx_start;

  // Oversized requests clamp to the register width; the transmit word is
  // left-aligned so the first bit to send always sits in the MSB.
  assign eff_len  = (t_size > (reg_width + 1)'(reg_width)) ? CW'(reg_width) : t_size[CW-1:0];
  assign shamt    = CW'(reg_width) - eff_len;
  assign tx_start = data_in << shamt;

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    bits_d  = bits_q;
    len_d   = len_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    case (state_q)
      IDLE: begin
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        if (t_begin && (eff_len != '0)) begin
          tx_d    = tx_start;
          len_d   = eff_len;
          rx_d    = '0;
          bits_d  = '0;
          cs_d    = 1'b0;
          mosi_d  = tx_start[reg_width-1];
          state_d = TRANSFER;
        end
      end
      TRANSFER: begin
        if (!sclk_q) begin
          sclk_d = 1'b1;
          rx_d   = {rx_q[reg_width-2:0], miso};
          bits_d = bits_q + CW'(1);
        end else begin
          sclk_d = 1'b0;
          if (bits_q == len_q) begin
            state_d = FINISH;
          end else begin
            // Rotate rather than shift so every transmit bit stays live.
            tx_d   = {tx_q[reg_width-2:0], tx_q[reg_width-1]};
            mosi_d = tx_q[reg_width-2];
          end
        end
      end
      FINISH: begin
        cs_d    = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        dout_d  = rx_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      bits_q  <= '0;
      len_q   <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      bits_q  <= bits_d;
      len_q   <= len_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end

  assign data_out = dout_q;
  assign cs       = cs_q;
  assign spi_clk  = sclk_q;
  assign mosi     = mosi_q;

endmodule

// File: tb/tb_simple_spi.sv
// Bench for simple_spi: a timeline model of each transfer is checked against
// the DUT pins every cycle, alongside directed and randomized transfers.
module tb_simple_spi;

  logic        clk;
  logic        rst;
  logic        t_begin;
  logic [15:0] data_in;
  logic [16:0] t_size;
  logic [15:0] data_out;
  logic        cs;
  logic        spi_clk;
  logic        mosi;
  logic        miso;

  simple_spi #(.reg_width(16)) dut (
    .sys_clk  (clk),
    .rst      (rst),
    .t_begin  (t_begin),
    .data_in  (data_in),
    .t_size   (t_size),
    .data_out (data_out),
    .cs       (cs),
    .spi_clk  (spi_clk),
    .mosi     (mosi),
    .miso     (miso)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // miso source: 0 = loopback from mosi, 1 = constant, 2 = random per cycle
  int   miso_mode = 0;
  logic miso_val  = 1'b0;

  // Transfer model: position on the timeline of edges since acceptance
  logic        m_valid  = 1'b0;
  logic        m_active = 1'b0;
  int          m_t      = 0;
  int          m_n      = 0;
  logic [15:0] m_d      = '0;
  logic [15:0] m_rx     = '0;
  logic [15:0] m_do     = '0;

  // Pin monitors, monotonic so callers difference snapshots
  int          pulses_total  = 0;
  int          cs_low_total  = 0;
  int          cs_fall_total = 0;
  logic [63:0] mosi_hist     = '0;
  logic        prev_sclk     = 1'b0;
  logic        prev_cs       = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: inputs are frozen across the rising edge, the model
  // advances with the values the DUT sampled, then the pins are compared.
  task automatic tick();
    logic        s_rst, s_tb, s_miso;
    logic [15:0] s_din;
    logic [16:0] s_tsz;
    logic        e_cs, e_sclk, e_mosi;
    int          idx;
    case (miso_mode)
      0:       miso = mosi;
      1:       miso = miso_val;
      default: miso = 1'($urandom_range(0, 1));
    endcase
    s_rst  = rst;
    s_tb   = t_begin;
    s_din  = data_in;
    s_tsz  = t_size;
    s_miso = miso;
    @(negedge clk);

    if (!s_rst) begin
      m_valid  = 1'b1;
      m_active = 1'b0;
      m_do     = '0;
    end else if (m_valid) begin
      if (!m_active) begin
        if (s_tb && s_tsz != 0) begin
          m_active = 1'b1;
          m_t      = 0;
          m_n      = (s_tsz > 17'd16) ? 16 : int'(s_tsz);
          m_d      = s_din;
          m_rx     = '0;
        end
      end else begin
        m_t++;
        if ((m_t % 2 == 1) && (m_t < 2 * m_n)) m_rx = {m_rx[14:0], s_miso};
        if (m_t == 2 * m_n + 1) begin
          m_do     = m_rx;
          m_active = 1'b0;
        end
      end
    end

    if (m_valid) begin
      if (spi_clk === 1'b1 && prev_sclk !== 1'b1) begin
        pulses_total++;
        mosi_hist = {mosi_hist[62:0], mosi};
      end
      if (cs === 1'b0) cs_low_total++;
      if (cs === 1'b0 && prev_cs === 1'b1) cs_fall_total++;
      prev_sclk = spi_clk;
      prev_cs   = cs;

      if (m_active) begin
        idx    = m_n - 1 - (((m_t / 2) < (m_n - 1)) ? (m_t / 2) : (m_n - 1));
        e_cs   = 1'b0;
        e_sclk = m_t[0];
        e_mosi = m_d[idx];
      end else begin
        e_cs   = 1'b1;
        e_sclk = 1'b0;
        e_mosi = 1'b0;
      end
      chk("cs", 32'(cs), 32'(e_cs));
      chk("spi_clk", 32'(spi_clk), 32'(e_sclk));
      chk("mosi", 32'(mosi), 32'(e_mosi));
      chk("data_out", 32'(data_out), 32'(m_do));
    end
  endtask

  task automatic wait_done();
    logic seen_low = 1'b0;
    logic done     = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (cs === 1'b0) seen_low = 1'b1;
      if (seen_low && cs === 1'b1) done = 1'b1;
      else tick();
    end
    chk("xfer_done", 32'(done), 32'd1);
  endtask

  task automatic run_xfer(input logic [15:0] din, input logic [16:0] tsz);
    data_in = din;
    t_size  = tsz;
    t_begin = 1'b1;
    tick();
    t_begin = 1'b0;
    wait_done();
  endtask

  int p0, l0, f0;

  task automatic snap();
    p0 = pulses_total;
    l0 = cs_low_total;
    f0 = cs_fall_total;
  endtask

  initial begin
    rst     = 1'b1;
    t_begin = 1'b0;
    data_in = '0;
    t_size  = '0;
    miso    = 1'b0;

    // Reset
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    chk("rst_cs", 32'(cs), 32'd1);
    chk("rst_sclk", 32'(spi_clk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_dout", 32'(data_out), 32'h0000);
    tick();

    // Loopback 16-bit
    miso_mode = 0;
    snap();
    run_xfer(16'h00EE, 17'd16);
    chk("ee_pulses", 32'(pulses_total - p0), 32'd16);
    chk("ee_mosi", 32'(mosi_hist[15:0]), 32'h00EE);
    chk("ee_cs_low", 32'(cs_low_total - l0), 32'd33);
    chk("ee_dout", 32'(data_out), 32'h00EE);
    tick();

    // Loopback 8-bit
    snap();
    run_xfer(16'hA5C3, 17'd8);
    chk("c3_pulses", 32'(pulses_total - p0), 32'd8);
    chk("c3_mosi", 32'(mosi_hist[7:0]), 32'hC3);
    chk("c3_cs_low", 32'(cs_low_total - l0), 32'd17);
    chk("c3_dout", 32'(data_out), 32'h00C3);
    tick();

    // miso tied high
    miso_mode = 1;
    miso_val  = 1'b1;
    snap();
    run_xfer(16'h0000, 17'd16);
    chk("ones_mosi", 32'(mosi_hist[15:0]), 32'h0000);
    chk("ones_dout", 32'(data_out), 32'hFFFF);
    tick();

    // t_begin re-pulsed mid-transfer
    miso_mode = 0;
    snap();
    data_in = 16'h1234;
    t_size  = 17'd4;
    t_begin = 1'b1;
    tick();
    t_begin = 1'b0;
    repeat (3) tick();
    t_begin = 1'b1;
    data_in = 16'hFFFF;
    t_size  = 17'd16;
    tick();
    t_begin = 1'b0;
    repeat (20) tick();
    chk("repulse_falls", 32'(cs_fall_total - f0), 32'd1);
    chk("repulse_pulses", 32'(pulses_total - p0), 32'd4);
    chk("repulse_dout", 32'(data_out), 32'h0004);

    // Reset mid-transfer
    data_in = 16'hBEEF;
    t_size  = 17'd16;
    t_begin = 1'b1;
    tick();
    t_begin = 1'b0;
    repeat (6) tick();
    rst = 1'b0;
    tick();
    chk("abort_cs", 32'(cs), 32'd1);
    chk("abort_dout", 32'(data_out), 32'h0000);
    rst = 1'b1;
    repeat (3) tick();

    // Zero length is a no-op
    snap();
    data_in = 16'hFFFF;
    t_size  = 17'd0;
    t_begin = 1'b1;
    repeat (5) tick();
    t_begin = 1'b0;
    tick();
    chk("zero_falls", 32'(cs_fall_total - f0), 32'd0);
    chk("zero_pulses", 32'(pulses_total - p0), 32'd0);

    // Oversized length clamps to 16 bits
    snap();
    run_xfer(16'hBEEF, 17'd17);
    chk("clamp_pulses", 32'(pulses_total - p0), 32'd16);
    chk("clamp_dout", 32'(data_out), 32'hBEEF);
    tick();

    // t_begin held: back-to-back 2-bit transfers, one idle cycle apart
    snap();
    data_in = 16'h0002;
    t_size  = 17'd2;
    t_begin = 1'b1;
    repeat (20) tick();
    t_begin = 1'b0;
    chk("held_falls", 32'(cs_fall_total - f0), 32'd4);
    repeat (8) tick();
    chk("held_dout", 32'(data_out), 32'h0002);

    // Randomized traffic with mid-transfer disturbances
    for (int it = 0; it < 40; it++) begin
      miso_mode = $urandom_range(0, 2);
      miso_val  = 1'($urandom_range(0, 1));
      data_in   = 16'($urandom);
      t_size    = 17'($urandom_range(0, 18));
      t_begin   = 1'b1;
      repeat ($urandom_range(1, 2)) tick();
      for (int j = 0; j < 40; j++) begin
        t_begin = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 4) == 0) begin
          data_in = 16'($urandom);
          t_size  = 17'($urandom_range(0, 18));
        end
        rst = !((it % 10 == 7) && (j == 10));
        tick();
      end
      t_begin = 1'b0;
      rst     = 1'b1;
      repeat (36) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
